// File: rtl/uart_transceiver_if.sv
// Byte-stream side of the UART: TX word handshake and RX word/status handshake.
// Latency: none, this is wiring only.
// Backpressure: tx_ready throttles the producer; rx_ready throttles the RX store.
interface uart_transceiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_din;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  // master = on-chip byte-stream logic, slave = the UART core
  modport master (
    output tx_din, tx_valid, rx_ready,
    input  tx_ready, rx_dout, rx_valid, rx_parity_err, rx_frame_err
  );
  modport slave (
    input  tx_din, tx_valid, rx_ready,
    output tx_ready, rx_dout, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART with a shared fractional (Q.6) 16x baud generator; optional RX FIFO via UART_RX_FIFO_EN.
// Latency: TX frame starts the clk after acceptance; an RX word is stored on the clk its stop bit is sampled.
// Backpressure: tx_ready low while a frame is in flight; a full RX store drops new words and sets rx_overrun.
module uart_transceiver #(
  parameter int DATA_BITS     = 8,
  parameter int DIV_WIDTH     = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data,
  output logic                 tx_data,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop_bits,
  output logic                 tx_busy,
  output logic                 rx_overrun,
  input  logic                 err_clear,
  output logic                 rx_busy,
  uart_transceiver_if.slave    bus
);

  localparam int SW = DATA_BITS + 2;  // stored entry: {frame_err, parity_err, data}

  // ---------------- baud generator ----------------
  logic [DIV_WIDTH-1:0] acc;
  logic [DIV_WIDTH:0]   acc_sum;
  logic [DIV_WIDTH:0]   acc_wrap;
  logic                 tick;

  assign acc_sum  = {1'b0, acc} + (DIV_WIDTH+1)'(64);
  assign acc_wrap = acc_sum - {1'b0, divisor};

  // Free-running fractional accumulator; a zero divisor freezes it so both FSMs stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (divisor == '0) begin
      tick <= 1'b0;
    end else if (acc_sum >= {1'b0, divisor}) begin
      tick <= 1'b1;
      acc  <= acc_wrap[DIV_WIDTH-1:0];
    end else begin
      tick <= 1'b0;
      acc  <= acc_sum[DIV_WIDTH-1:0];
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [4:0]           tx_cnt;
  logic [3:0]           tx_idx;
  logic                 tx_par_en;
  logic                 tx_par_bit;
  logic                 tx_two_stop;
  logic                 tx_line;
  logic                 tx_rdy;
  logic                 tx_busy_r;

  // TX frame sequencer; frame options are latched with the word so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '0;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_line     <= 1'b1;
      tx_rdy      <= 1'b1;
      tx_busy_r   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_valid && tx_rdy) begin
            tx_state    <= TX_START;
            tx_shift    <= bus.tx_din;
            tx_cnt      <= '0;
            tx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            tx_par_bit  <= (parity_mode == 2'b10) ? ~(^bus.tx_din) : (^bus.tx_din);
            tx_two_stop <= two_stop_bits;
            tx_line     <= 1'b0;
            tx_rdy      <= 1'b0;
            tx_busy_r   <= 1'b1;
          end
        end
        TX_START: begin
          if (tick) begin
            if (tx_cnt == 5'd15) begin
              tx_cnt   <= '0;
              tx_idx   <= '0;
              tx_state <= TX_DATA;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end else begin
              tx_cnt <= tx_cnt + 5'd1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (tx_cnt == 5'd15) begin
              tx_cnt <= '0;
              if (tx_idx == 4'(DATA_BITS-1)) begin
                if (tx_par_en) begin
                  tx_state <= TX_PARITY;
                  tx_line  <= tx_par_bit;
                end else begin
                  tx_state <= TX_STOP;
                  tx_line  <= 1'b1;
                end
              end else begin
                tx_idx   <= tx_idx + 4'd1;
                tx_line  <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
              end
            end else begin
              tx_cnt <= tx_cnt + 5'd1;
            end
          end
        end
        TX_PARITY: begin
          if (tick) begin
            if (tx_cnt == 5'd15) begin
              tx_cnt   <= '0;
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_cnt <= tx_cnt + 5'd1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (tx_cnt == (tx_two_stop ? 5'd31 : 5'd15)) begin
              tx_cnt    <= '0;
              tx_state  <= TX_IDLE;
              tx_rdy    <= 1'b1;
              tx_busy_r <= 1'b0;
            end else begin
              tx_cnt <= tx_cnt + 5'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_data      = tx_line;
  assign tx_busy      = tx_busy_r;
  assign bus.tx_ready = tx_rdy;

  // ---------------- receiver ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  // Metastability synchroniser; resets to idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_sync <= '1;
    else       rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_data};
  end
  assign rx_s = rx_sync[SYNC_STAGES-1];

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_cnt;
  logic [3:0]           rx_idx;
  logic                 rx_par_en;
  logic                 rx_par_odd;
  logic                 rx_par_acc;
  logic                 rx_par_err;
  logic                 rx_busy_r;
  logic                 rx_wr;
  logic [SW-1:0]        rx_wr_dat;

  // The stop-bit sample instant is also the store write strobe.
  assign rx_wr     = (rx_state == RX_STOP) && tick && (rx_cnt == 4'd15);
  assign rx_wr_dat = {~rx_s, rx_par_err, rx_shift};

  // RX frame sequencer: mid-bit sampling from the start-bit centre, 16 ticks per bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_acc <= 1'b0;
      rx_par_err <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state   <= RX_START;
            rx_cnt     <= '0;
            rx_busy_r  <= 1'b1;
            rx_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            rx_par_odd <= (parity_mode == 2'b10);
            rx_par_err <= 1'b0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_cnt == 4'd7) begin
              rx_cnt <= '0;
              if (!rx_s) begin
                rx_state   <= RX_DATA;
                rx_idx     <= '0;
                rx_par_acc <= 1'b0;
              end else begin
                rx_state  <= RX_IDLE;
                rx_busy_r <= 1'b0;
              end
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_shift   <= {rx_s, rx_shift[DATA_BITS-1:1]};
              rx_par_acc <= rx_par_acc ^ rx_s;
              if (rx_idx == 4'(DATA_BITS-1)) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
              else                           rx_idx   <= rx_idx + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              rx_par_err <= rx_par_acc ^ rx_s ^ rx_par_odd;
              rx_state   <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              if (rx_s) begin
                rx_state  <= RX_IDLE;
                rx_busy_r <= 1'b0;
              end else begin
                rx_state <= RX_BREAK;
              end
            end
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            rx_state  <= RX_IDLE;
            rx_busy_r <= 1'b0;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_busy = rx_busy_r;

  // ---------------- RX store ----------------
  logic          st_vld;
  logic [SW-1:0] st_head;
  logic          st_pop;
  logic          st_drop;

  assign st_pop = st_vld && bus.rx_ready;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [SW-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic          push;

  assign fifo_full = (fifo_cnt == (AW+1)'(RX_FIFO_DEPTH));
  assign push      = rx_wr && (!fifo_full || st_pop);
  assign st_drop   = rx_wr && fifo_full && !st_pop;
  assign st_vld    = (fifo_cnt != '0);
  assign st_head   = fifo_mem[rd_ptr];

  // First-word-fall-through FIFO; a push alongside a pop is accepted even when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_wr_dat;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (st_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, st_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic          hold_vld;
  logic [SW-1:0] hold_dat;
  logic          unused_fifo_depth;

  // Depth only matters in the FIFO build.
  assign unused_fifo_depth = ^RX_FIFO_DEPTH;
  assign st_drop = rx_wr && hold_vld && !st_pop;
  assign st_vld  = hold_vld;
  assign st_head = hold_dat;

  // Single holding register; a write on the pop clk replaces the word without a gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (rx_wr && (!hold_vld || st_pop)) begin
      hold_vld <= 1'b1;
      hold_dat <= rx_wr_dat;
    end else if (st_pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // Sticky overrun flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rx_overrun <= 1'b0;
    else if (st_drop)   rx_overrun <= 1'b1;
    else if (err_clear) rx_overrun <= 1'b0;
  end

  assign bus.rx_valid      = st_vld;
  assign bus.rx_dout       = st_head[DATA_BITS-1:0];
  assign bus.rx_parity_err = st_head[DATA_BITS];
  assign bus.rx_frame_err  = st_head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: TX waveform, loopback RX, error frames, glitch, overrun, reset.
// Latency: expectations come from frame arithmetic (bit = divisor/4 clk) with a small phase tolerance.
// Backpressure: rx_ready held low where the store-full behaviour is exercised.
module tb_uart_transceiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        drv_line;
  logic        loopback;
  logic        rx_line;
  logic        tx_data;
  logic [31:0] divisor;
  logic [1:0]  parity_mode;
  logic        two_stop_bits;
  logic        tx_busy;
  logic        rx_overrun;
  logic        err_clear;
  logic        rx_busy;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef UART_RX_FIFO_EN
  localparam int STORE_CAP = 4;
`else
  localparam int STORE_CAP = 1;
`endif

  uart_transceiver_if #(.DATA_BITS(8)) bus ();

  uart_transceiver #(
    .DATA_BITS(8), .DIV_WIDTH(32), .SYNC_STAGES(2), .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_line), .tx_data(tx_data),
    .divisor(divisor), .parity_mode(parity_mode), .two_stop_bits(two_stop_bits),
    .tx_busy(tx_busy), .rx_overrun(rx_overrun), .err_clear(err_clear),
    .rx_busy(rx_busy), .bus(bus)
  );

  assign rx_line = loopback ? tx_data : drv_line;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Serial frame as the line should carry it, bit 0 first.
  function automatic int build_frame(input logic [7:0] w, input logic [1:0] pm, input logic ts,
                                     input logic par_flip, input logic stop_val,
                                     output logic [15:0] bits);
    int n;
    n = 0;
    bits = '1;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = w[i]; n++; end
    if (pm == 2'b01)      begin bits[n] = (^w) ^ par_flip;    n++; end
    else if (pm == 2'b10) begin bits[n] = (~(^w)) ^ par_flip; n++; end
    bits[n] = stop_val; n++;
    if (ts) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  // Send one word on TX and check every bit centre and the frame length.
  task automatic tx_frame_check(input logic [7:0] w, input logic [1:0] pm, input logic ts,
                                input logic scramble, input string name);
    logic [15:0] bits;
    int n, t, wt, bclk;
    bclk = int'(divisor / 4);
    n = build_frame(w, pm, ts, 1'b0, 1'b1, bits);
    parity_mode = pm;
    two_stop_bits = ts;
    @(negedge clk);
    wt = 0;
    while (bus.tx_ready !== 1'b1 && wt < 2000) begin @(negedge clk); wt++; end
    n_cmp++;
    if (bus.tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready_wait: got %b want 1", name, bus.tx_ready);
    end
    bus.tx_din = w;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    t = 0;
    if (scramble) begin parity_mode = ~pm; two_stop_bits = ~ts; end
    n_cmp++;
    if ({bus.tx_ready, tx_busy, tx_data} !== 3'b010) begin
      n_fail++; $display("FAIL %s_accept: got rdy/busy/tx=%b want 010", name, {bus.tx_ready, tx_busy, tx_data});
    end
    for (int i = 0; i < n; i++) begin
      while (t < bclk/2 + bclk*i) begin @(negedge clk); t++; end
      n_cmp++;
      if (tx_data !== bits[i]) begin
        n_fail++; $display("FAIL %s_bit%0d: got %b want %b", name, i, tx_data, bits[i]);
      end
    end
    while (bus.tx_ready !== 1'b1 && t < bclk*n + 200) begin @(negedge clk); t++; end
    n_cmp++;
    if (bus.tx_ready !== 1'b1 || t < bclk*n - 3 || t > bclk*n + 3) begin
      n_fail++; $display("FAIL %s_len: got %0d clk want %0d", name, t, bclk*n);
    end
    parity_mode = pm;
    two_stop_bits = ts;
  endtask

  // Drive a bit pattern on the RX line from the bench, one bit per bit period.
  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drv_line = bits[i];
      repeat (int'(divisor / 4)) @(negedge clk);
    end
  endtask

  task automatic pop_word;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_data, bus.tx_ready, tx_busy, bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err, rx_overrun, rx_busy} !== 8'b11000000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 11000000",
        {tx_data, bus.tx_ready, tx_busy, bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err, rx_overrun, rx_busy});
    end
    n_cmp++;
    if (bus.rx_dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout: got %h want 00", bus.rx_dout);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_data, bus.tx_ready, tx_busy, bus.rx_valid, rx_busy} !== 5'b11000) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 11000", {tx_data, bus.tx_ready, tx_busy, bus.rx_valid, rx_busy});
    end
  endtask

  task automatic test_tx_basic;
    loopback = 1'b0;
    tx_frame_check(8'hA5, 2'b00, 1'b0, 1'b0, "tx_a5");
  endtask

  task automatic test_tx_random;
    loopback = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tx_frame_check(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, "tx_rand");
    end
  endtask

  task automatic test_loopback;
    logic [7:0] w;
    logic [1:0] pm;
    loopback = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w  = (k == 0) ? 8'h3C : 8'($urandom);
      pm = (k == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      tx_frame_check(w, pm, (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, "lb_tx");
      n_cmp++;
      if ({bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_dout} !== {3'b100, w}) begin
        n_fail++; $display("FAIL lb_rx%0d: got v/fe/pe/d=%b/%b/%b/%h want 1/0/0/%h",
          k, bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_dout, w);
      end
      pop_word();
      n_cmp++;
      if (bus.rx_valid !== 1'b0) begin
        n_fail++; $display("FAIL lb_pop%0d: got rx_valid=%b want 0", k, bus.rx_valid);
      end
    end
    loopback = 1'b0;
  endtask

  // Bench-driven frames with injected parity and stop-bit faults.
  task automatic test_rx_errors;
    logic [15:0] bits;
    logic [7:0]  w;
    logic [1:0]  pm;
    logic        flip, stop_v, exp_pe;
    int n;
    loopback = 1'b0;
    for (int k = 0; k < 7; k++) begin
      w      = (k == 0) ? 8'h55 : 8'($urandom);
      pm     = (k == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      flip   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      stop_v = (k == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      exp_pe = flip && (pm == 2'b01 || pm == 2'b10);
      parity_mode = pm;
      repeat (4) @(negedge clk);
      n = build_frame(w, pm, 1'b0, flip, stop_v, bits);
      drive_bits(bits, n);
      if (!stop_v) begin
        repeat (64) @(negedge clk);
        n_cmp++;
        if (rx_busy !== 1'b1) begin
          n_fail++; $display("FAIL rx_break_hold%0d: got rx_busy=%b want 1", k, rx_busy);
        end
      end
      n_cmp++;
      if ({bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_dout} !== {1'b1, ~stop_v, exp_pe, w}) begin
        n_fail++; $display("FAIL rx_err%0d: got v/fe/pe/d=%b/%b/%b/%h want 1/%b/%b/%h",
          k, bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_dout, ~stop_v, exp_pe, w);
      end
      drv_line = 1'b1;
      pop_word();
      repeat (8) @(negedge clk);
      n_cmp++;
      if ({rx_busy, bus.rx_valid} !== 2'b00) begin
        n_fail++; $display("FAIL rx_idle%0d: got busy/valid=%b want 00", k, {rx_busy, bus.rx_valid});
      end
    end
    parity_mode = 2'b00;
  endtask

  task automatic test_glitch;
    loopback = 1'b0;
    drv_line = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_detect: got rx_busy=%b want 1", rx_busy);
    end
    repeat (2) @(negedge clk);
    drv_line = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++;
    if ({rx_busy, bus.rx_valid} !== 2'b00) begin
      n_fail++; $display("FAIL glitch_reject: got busy/valid=%b want 00", {rx_busy, bus.rx_valid});
    end
  endtask

  task automatic test_overrun;
    logic [7:0] q[$];
    logic [7:0] w;
    loopback = 1'b1;
    bus.rx_ready = 1'b0;
    for (int k = 0; k <= STORE_CAP; k++) begin
      w = 8'($urandom);
      if (k < STORE_CAP) q.push_back(w);
      tx_frame_check(w, 2'b00, 1'b0, 1'b0, "ovr_tx");
      n_cmp++;
      if (rx_overrun !== (k == STORE_CAP)) begin
        n_fail++; $display("FAIL ovr_flag%0d: got %b want %b", k, rx_overrun, (k == STORE_CAP));
      end
    end
    while (q.size() > 0) begin
      w = q.pop_front();
      n_cmp++;
      if ({bus.rx_valid, bus.rx_dout} !== {1'b1, w}) begin
        n_fail++; $display("FAIL ovr_keep: got v/d=%b/%h want 1/%h", bus.rx_valid, bus.rx_dout, w);
      end
      pop_word();
    end
    n_cmp++;
    if ({bus.rx_valid, rx_overrun} !== 2'b01) begin
      n_fail++; $display("FAIL ovr_sticky: got valid/ovr=%b want 01", {bus.rx_valid, rx_overrun});
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    n_cmp++;
    if (rx_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: got %b want 0", rx_overrun);
    end
    loopback = 1'b0;
  endtask

  task automatic test_divisor_zero;
    int t;
    loopback = 1'b0;
    parity_mode = 2'b00;
    two_stop_bits = 1'b0;
    bus.tx_din = 8'h81;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    divisor = 32'd0;
    repeat (200) @(negedge clk);
    n_cmp++;
    if ({tx_data, bus.tx_ready, tx_busy} !== 3'b001) begin
      n_fail++; $display("FAIL div0_stall: got tx/rdy/busy=%b want 001", {tx_data, bus.tx_ready, tx_busy});
    end
    divisor = 32'd128;
    t = 208;
    while (bus.tx_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    n_cmp++;
    if (bus.tx_ready !== 1'b1 || t < 320 + 200 - 6 || t > 320 + 200 + 6) begin
      n_fail++; $display("FAIL div0_resume: got %0d clk want %0d", t, 520);
    end
  endtask

  task automatic test_reset_mid;
    loopback = 1'b1;
    tx_frame_check(8'h96, 2'b00, 1'b0, 1'b0, "rst_pre");
    bus.tx_din = 8'h5A;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({tx_data, bus.tx_ready, tx_busy, bus.rx_valid, rx_busy} !== 5'b11000) begin
      n_fail++; $display("FAIL rst_mid: got tx/rdy/busy/rxv/rxb=%b want 11000",
        {tx_data, bus.tx_ready, tx_busy, bus.rx_valid, rx_busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    loopback = 1'b0;
    tx_frame_check(8'($urandom), 2'b01, 1'b1, 1'b0, "rst_post");
  endtask

  initial begin
    reset = 1'b1;
    drv_line = 1'b1;
    loopback = 1'b0;
    divisor = 32'd128;
    parity_mode = 2'b00;
    two_stop_bits = 1'b0;
    err_clear = 1'b0;
    bus.tx_din = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_random();
    test_loopback();
    test_rx_errors();
    test_glitch();
    test_overrun();
    test_divisor_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
